apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Single-clock APB master that shares one APB port among NUM_REQ local requesters using round-robin arbitration.
- Sequences each granted request through APB SETUP/ACCESS phases and routes read data and completion back to the winning requester.
- Sits on the APB side, between local register clients and an APB slave or decoder, in the apb_pclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- APB_ADDR_WIDTH, 32, paddr width.
- APB_DATA_WIDTH, 32, pwdata/prdata width.
- TIMEOUT_CYCLES, 16, ACCESS wait limit; used only with APB_TIMEOUT_EN.

Ports:
- apb_pclk  input  1  clock.
- apb_prstn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_write  input  NUM_REQ  1=write, 0=read.
- req_addr  input  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  input  NUM_REQ*APB_DATA_WIDTH  packed write data.
- req_ack  output  NUM_REQ  one-hot pulse: request accepted and fields latched.
- rsp_done  output  NUM_REQ  one-hot pulse: transfer complete.
- rsp_rdata  output  APB_DATA_WIDTH  read data, valid while any rsp_done is high.
- rsp_err  output  1  error flag, valid with rsp_done.
- apb_psel  output  1  APB select.
- apb_penable  output  1  APB enable.
- apb_pwrite  output  1  APB direction.
- apb_paddr  output  APB_ADDR_WIDTH  APB address.
- apb_pwdata  output  APB_DATA_WIDTH  APB write data.
- apb_pready  input  1  slave ready.
- apb_prdata  input  APB_DATA_WIDTH  slave read data.

Behaviour:
- Clocking and reset: one clock, apb_pclk. Reset is asynchronous, active-low, on apb_prstn.
- Reset values: all outputs 0, state IDLE, round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE, with any req_valid high at the clock edge:
  - Winner is the first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - Latch the winner's write/addr/wdata into apb_pwrite/apb_paddr/apb_pwdata.
  - Set apb_psel=1 and pulse req_ack[winner] for one cycle.
  - Pointer becomes the winner index; go to SETUP.
  - With no request, stay in IDLE with psel=0.
- SETUP: psel=1, penable=0. Always advance to ACCESS with penable=1.
- ACCESS, pready=0: hold all APB outputs.
- ACCESS, pready=1:
  - Drop psel and penable to 0.
  - Pulse rsp_done[winner] for one cycle.
  - rsp_rdata = prdata on reads, 0 on writes; rsp_err=0.
  - Go to IDLE.
- Minimum latency: request visible at cycle 0, SETUP cycle 1, ACCESS cycle 2 with pready=1, rsp_done high cycle 3. Re-arbitration happens in cycle 3, so throughput is one transfer per 3 cycles.
- Requester rules:
  - Hold req_valid and fields stable until req_ack.
  - May change or drop them in the cycle after req_ack.
  - A requester may not issue its next request until its rsp_done.
  - Dropping req_valid before ack withdraws the request; it is never granted.
- Requests arriving during SETUP/ACCESS wait; they are not queued beyond req_valid.
- All requesters valid continuously: grants rotate 0,1,2,3,0,...
- paddr/pwdata/pwrite keep their last values after completion; they are not cleared.
- Reset mid-transfer: returns to IDLE immediately with psel=penable=0. The in-flight request gets no rsp_done; the requester must reissue.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter counts ACCESS cycles with pready=0 and clears on entering ACCESS.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer is terminated: psel=penable=0, rsp_done[winner] pulse, rsp_err=1, rsp_rdata=0, state IDLE.
  - pready=1 in the same cycle as the limit takes priority: normal completion, rsp_err=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

Decomposition:
- Package apb_rr_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and a TIMEOUT counter-width function.
- Sub-module rr_arbiter(NUM_REQ): combinational one-hot winner from the request vector and pointer. It is instantiated once; the pointer register stays in the parent.

Test Plan:
- Single write, req0 addr=100 wdata=200, pready tied 1 -> ack0 cycle 1; psel cycle 1-2; penable cycle 2; paddr=100, pwdata=200, pwrite=1; done0 cycle 3; rsp_err=0.
- Read, req2 addr=104, prdata=255, pready low 3 ACCESS cycles then high -> psel/penable held 4 ACCESS cycles; done2 with rsp_rdata=255.
- All four requesters valid continuously, pready=1 -> ack order 0,1,2,3,0; no starvation; one transfer per 3 cycles.
- req1 and req3 valid simultaneously after last grant=1 -> req3 wins, then req1.
- apb_prstn asserted during ACCESS -> psel/penable/req_ack/rsp_done 0 immediately; no rsp_done for in-flight request; after release, req0 wins first.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, pready held 0 -> done pulse after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0. Repeat with pready rising on cycle 16 -> rsp_err=0.

Source files
------------

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: FSM encoding and timeout counter sizing shared by apb_rr_master.
// The timeout counter is only built when APB_TIMEOUT_EN is defined.
package apb_rr_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Counter only needs to reach cycles-1, the last tolerated wait cycle.
    function automatic int tmo_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first request after i_ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);
    logic [PW-1:0] w_k;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = PW'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                o_grant[w_k] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin shares one APB master port among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to terminate ACCESS phases stalled for TIMEOUT_CYCLES with rsp_err.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               apb_pclk,
    input  logic                               apb_prstn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 rsp_done,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
    output logic                               rsp_err,
    output logic                               apb_psel,
    output logic                               apb_penable,
    output logic                               apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]          apb_paddr,
    output logic [APB_DATA_WIDTH-1:0]          apb_pwdata,
    input  logic                               apb_pready,
    input  logic [APB_DATA_WIDTH-1:0]          apb_prdata
);
    localparam int PW = $clog2(NUM_REQ);

    logic [1:0]                r_state;
    logic [PW-1:0]             r_ptr;
    logic [NUM_REQ-1:0]        r_ack;
    logic [NUM_REQ-1:0]        r_done;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;

    logic [NUM_REQ-1:0]        w_grant;
    logic [PW-1:0]             w_idx;
    logic                      w_write;
    logic [APB_ADDR_WIDTH-1:0] w_addr;
    logic [APB_DATA_WIDTH-1:0] w_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_idx   = '0;
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_idx   = PW'(i);
                w_write = req_write[i];
                w_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                w_wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = tmo_width(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PW'(NUM_REQ - 1);
            r_ack     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
`ifdef APB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_ack   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: if (|req_valid) begin
                    r_ack    <= w_grant;
                    r_ptr    <= w_idx;
                    r_pwrite <= w_write;
                    r_paddr  <= w_addr;
                    r_pwdata <= w_wdata;
                    r_psel   <= 1'b1;
                    r_state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                ST_ACCESS: if (apb_pready) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_done    <= NUM_REQ'(1) << r_ptr;
                    r_rdata   <= r_pwrite ? '0 : apb_prdata;
                    r_state   <= ST_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_done    <= NUM_REQ'(1) << r_ptr;
                    r_err     <= 1'b1;
                    r_state   <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ack     = r_ack;
    assign rsp_done    = r_done;
    assign rsp_rdata   = r_rdata;
    assign apb_psel    = r_psel;
    assign apb_penable = r_penable;
    assign apb_pwrite  = r_pwrite;
    assign apb_paddr   = r_paddr;
    assign apb_pwdata  = r_pwdata;
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed and random transfers checked against a round-robin reference model.
module tb_apb_rr_master;
    localparam int N  = 4;
    localparam int PW = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            apb_prstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rsp_done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            apb_psel;
    logic            apb_penable;
    logic            apb_pwrite;
    logic [AW-1:0]   apb_paddr;
    logic [DW-1:0]   apb_pwdata;
    logic            apb_pready = 1'b0;
    logic [DW-1:0]   apb_prdata = '0;

    int errors = 0;
    int checks = 0;
    int last   = N - 1;

    always #5 clk = ~clk;

    apb_rr_master #(
        .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .apb_pclk    (clk),
        .apb_prstn   (apb_prstn),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .rsp_done    (rsp_done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_pready  (apb_pready),
        .apb_prdata  (apb_prdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int l);
        for (int i = 1; i <= N; i++)
            if (v[PW'((l + i) % N)]) return (l + i) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[PW'(i)]      = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // One complete transfer starting in IDLE; waits = pready-low ACCESS cycles before ready.
    task automatic xfer(input logic [N-1:0] v, input int waits, input logic [DW-1:0] rd);
        int w, low;
        logic to, wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        w  = pick(v, last);
        wr = req_write[PW'(w)];
        ad = req_addr[w*AW +: AW];
        wd = req_wdata[w*DW +: DW];
        req_valid = v;
        step();
        chk("ack", 64'(req_ack), 64'(N'(1) << w));
        chk("setup_psel", 64'(apb_psel), 64'd1);
        chk("setup_penable", 64'(apb_penable), 64'd0);
        chk("pwrite", 64'(apb_pwrite), 64'(wr));
        chk("paddr", 64'(apb_paddr), 64'(ad));
        chk("pwdata", 64'(apb_pwdata), 64'(wd));
        chk("early_done", 64'(rsp_done), 64'd0);
        req_valid = '0;
        step();
        chk("access_penable", 64'(apb_penable), 64'd1);
        chk("access_psel", 64'(apb_psel), 64'd1);
        chk("ack_pulse", 64'(req_ack), 64'd0);
        low = waits;
        to  = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) begin
            low = TO;
            to  = 1'b1;
        end
`endif
        for (int k = 0; k < low; k++) begin
            chk("hold_psel", 64'(apb_psel & apb_penable), 64'd1);
            chk("hold_done", 64'(rsp_done), 64'd0);
            chk("hold_paddr", 64'(apb_paddr), 64'(ad));
            step();
        end
        if (!to) begin
            apb_pready = 1'b1;
            apb_prdata = rd;
            step();
            apb_pready = 1'b0;
        end
        chk("done", 64'(rsp_done), 64'(N'(1) << w));
        chk("rdata", 64'(rsp_rdata), (to || wr) ? 64'd0 : 64'(rd));
        chk("err", 64'(rsp_err), 64'(to));
        chk("end_psel", 64'(apb_psel | apb_penable), 64'd0);
        chk("kept_paddr", 64'(apb_paddr), 64'(ad));
        last = w;
    endtask

    initial begin
        step();
        step();
        chk("rst_out", 64'({req_ack, rsp_done, apb_psel, apb_penable, apb_pwrite, rsp_err}), 64'd0);
        chk("rst_bus", 64'(apb_paddr | apb_pwdata | rsp_rdata), 64'd0);
        apb_prstn = 1'b1;
        step();

        set_req(0, 1'b1, 32'd100, 32'd200);
        xfer(4'b0001, 0, 32'd0);

        set_req(2, 1'b0, 32'd104, 32'd0);
        xfer(4'b0100, 3, 32'd255);

        set_req(1, 1'b1, 32'h11, 32'h1111);
        set_req(3, 1'b0, 32'h33, 32'h3333);
        xfer(4'b0010, 0, 32'h0);
        xfer(4'b1010, 0, 32'hAA);
        xfer(4'b1010, 1, 32'hBB);

        for (int i = 0; i < 6; i++) xfer(4'b1111, 0, 32'(i + 7));

        // Reset during ACCESS: the in-flight transfer must vanish without rsp_done.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        #2 apb_prstn = 1'b0;
        #1;
        chk("mid_rst_psel", 64'({apb_psel, apb_penable}), 64'd0);
        chk("mid_rst_pulse", 64'({req_ack, rsp_done}), 64'd0);
        step();
        apb_prstn  = 1'b1;
        apb_pready = 1'b1;
        step();
        chk("no_done_after_rst", 64'(rsp_done), 64'd0);
        apb_pready = 1'b0;
        last = N - 1;
        xfer(4'b1111, 0, 32'h5A5A);

        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < N; r++) set_req(r, 1'($urandom), $urandom, $urandom);
            xfer(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), $urandom);
        end

`ifdef APB_TIMEOUT_EN
        set_req(1, 1'b0, 32'h40, 32'h0);
        xfer(4'b0010, TO, 32'hDEAD);
        xfer(4'b0010, TO - 1, 32'hBEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
